game_sprite_bounce_ctrl: RTL and testbench
==========================================

Name: game_sprite_bounce_ctrl

Overview:
Upstream motion controller for one game sprite. It drives the sprite-control write and update strobes (write_xy, write_dxy, enable_update) and reads back the sprite's current x/y. It places the sprite at a start position, then advances it once per frame tick, reversing dx/dy on screen edges. It sits between the game top-level FSM (launch/halt) and the sprite block.

Parameters:
SCREEN_WIDTH, 640, visible width in pixels
SCREEN_HEIGHT, 480, visible height in pixels
SPRITE_WIDTH, 8, sprite width in pixels
SPRITE_HEIGHT, 8, sprite height in pixels
X_WIDTH, 10, x coordinate width
Y_WIDTH, 10, y coordinate width
DX_WIDTH, 2, x speed width, two's complement
DY_WIDTH, 2, y speed width, two's complement
START_X, 0, launch x
START_Y, 0, launch y
START_DX, 1, launch dx; must not be the most-negative value
START_DY, 1, launch dy; must not be the most-negative value
STROBE_WIDTH, 20, frame-tick counter width
STROBE_PERIOD, 416667, clocks per tick (60 Hz at 25 MHz)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
launch  in  1  start pulse, honoured only in IDLE
halt  in  1  stop request, any non-IDLE state
sprite_x  in  X_WIDTH  current sprite x from sprite block
sprite_y  in  Y_WIDTH  current sprite y from sprite block
sprite_write_xy  out  1  load position strobe
sprite_write_dxy  out  1  load speed strobe
sprite_write_x  out  X_WIDTH  position x to load
sprite_write_y  out  Y_WIDTH  position y to load
sprite_write_dx  out  DX_WIDTH  speed dx to load
sprite_write_dy  out  DY_WIDTH  speed dy to load
sprite_enable_update  out  1  advance-one-step strobe
busy  out  1  state != IDLE
bounce_count  out  8  saturating edge-bounce counter

Behaviour:
- States: IDLE, PLACE, AIM, MOVE, UPDATE, CHECK, BOUNCE. Strobe outputs are Moore-decoded from the state register.
- Reset (reset=0): state IDLE, all strobes 0, dx/dy regs = START_DX/START_DY, bounce_count 0, tick counter 0.
- sprite_write_x/y are constant START_X/START_Y. sprite_write_dx/dy always show the internal dx/dy regs.
- IDLE: launch=1 -> PLACE. Otherwise stay.
- PLACE (1 cycle): sprite_write_xy=1. Load dx/dy regs = START values. bounce_count=0. -> AIM.
- AIM (1 cycle): sprite_write_dxy=1. -> MOVE.
- MOVE: wait for tick. On tick -> UPDATE.
- UPDATE (1 cycle): sprite_enable_update=1. -> CHECK.
- CHECK (1 cycle): samples sprite_x/y. The sprite block has already registered the step.
  - hit_x = (dx<0 and sprite_x+dx<0) or (dx>0 and sprite_x+SPRITE_WIDTH+dx>SCREEN_WIDTH).
  - hit_y uses the same rule with dy, sprite_y, SPRITE_HEIGHT, SCREEN_HEIGHT.
  - All comparisons use signed (X_WIDTH+2)/(Y_WIDTH+2)-bit arithmetic; no truncation.
  - Any hit -> BOUNCE; else -> MOVE.
- BOUNCE (1 cycle):
  - Negate dx if hit_x and dy if hit_y (two's-complement, mod 2^DX_WIDTH). This register update happens on entry.
  - sprite_write_dxy=1 carries the new values.
  - bounce_count +1 once per BOUNCE even on a corner (both axes), saturating at 255.
  - -> MOVE.
- dx=0 or dy=0: that axis never hits.
- Tick counter: free-running 0..STROBE_PERIOD-1, wraps to 0. tick=1 when counter==STROBE_PERIOD-1. Ticks outside MOVE are dropped, not queued.
- halt=1 in any non-IDLE state -> IDLE next edge. halt has priority over all transitions. dx/dy and bounce_count are held.
- launch outside IDLE is ignored. launch and halt together in IDLE -> PLACE.
- At most one strobe is high in any cycle.
- Async reset mid-motion returns to IDLE immediately and clears all strobes.

Optional Feature:
GAME_SPRITE_BOTTOM_MISS_EN
- Defined: a bottom-edge hit (dy>0 and hit_y) in CHECK goes -> PLACE, not BOUNCE. This relaunches from START with START speeds and clears bounce_count to 0; any simultaneous hit_x is ignored.
- Undefined: the bottom edge bounces like the other edges.

Test Plan:
Bench setup: STROBE_PERIOD=4 and a behavioural sprite-control model (x+=dx, y+=dy on enable_update, registered).
1. Reset, launch pulse -> PLACE write_xy with (0,0), next cycle AIM write_dxy with (1,1); busy=1; first enable_update within 4 clocks of MOVE entry.
2. Start (628,100), dx=1 -> steps to x=632; CHECK sees 632+8+1>640 -> BOUNCE write_dx=2'b11; bounce_count=1; x then decreases.
3. Start (0,0), dx=dy=-1 -> corner: one BOUNCE with dx=dy=+1; bounce_count +1 only.
4. halt asserted during UPDATE -> IDLE next edge, no further strobes, dx/dy held; launch restarts from START, bounce_count 0.
5. Force 300 bounces -> bounce_count saturates at 255.
6. Macro defined, sprite reaches y=472 with dy=+1 -> PLACE write_xy (START_X,START_Y), bounce_count 0. Macro undefined, same case -> BOUNCE, dy=-1.

Source files
------------

// File: rtl/game_sprite_bounce_ctrl_if.sv
// Sprite-control bus between the bounce controller (master) and the sprite block (slave).
// The master drives the load/update strobes and the values to load, and reads back
// the current sprite position.
interface game_sprite_bounce_ctrl_if #(
    parameter int X_WIDTH  = 10,
    parameter int Y_WIDTH  = 10,
    parameter int DX_WIDTH = 2,
    parameter int DY_WIDTH = 2
);
    logic [X_WIDTH-1:0]  sprite_x;
    logic [Y_WIDTH-1:0]  sprite_y;
    logic                sprite_write_xy;
    logic                sprite_write_dxy;
    logic [X_WIDTH-1:0]  sprite_write_x;
    logic [Y_WIDTH-1:0]  sprite_write_y;
    logic [DX_WIDTH-1:0] sprite_write_dx;
    logic [DY_WIDTH-1:0] sprite_write_dy;
    logic                sprite_enable_update;

    modport master (
        input  sprite_x, sprite_y,
        output sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y,
        output sprite_write_dx, sprite_write_dy, sprite_enable_update
    );

    modport slave (
        output sprite_x, sprite_y,
        input  sprite_write_xy, sprite_write_dxy, sprite_write_x, sprite_write_y,
        input  sprite_write_dx, sprite_write_dy, sprite_enable_update
    );
endinterface

// File: rtl/game_sprite_bounce_ctrl.sv
// Motion controller for one sprite: places it at the start position, loads its speed,
// then steps it once per frame tick and reverses dx/dy when the next step would leave
// the screen. Counts edge bounces (saturating at 255).
// Optional macro GAME_SPRITE_BOTTOM_MISS_EN: a bottom-edge hit relaunches the sprite
// from the start position instead of bouncing.
module game_sprite_bounce_ctrl #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int DX_WIDTH      = 2,
    parameter int DY_WIDTH      = 2,
    parameter int START_X       = 0,
    parameter int START_Y       = 0,
    parameter int START_DX      = 1,
    parameter int START_DY      = 1,
    parameter int STROBE_WIDTH  = 20,
    parameter int STROBE_PERIOD = 416667
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      launch,
    input  logic                      halt,
    game_sprite_bounce_ctrl_if.master spr,
    output logic                      busy,
    output logic [7:0]                bounce_count
);

    localparam int XW = X_WIDTH + 2;
    localparam int YW = Y_WIDTH + 2;

    localparam logic signed [XW-1:0] SPRITE_W_S = XW'(SPRITE_WIDTH);
    localparam logic signed [XW-1:0] SCREEN_W_S = XW'(SCREEN_WIDTH);
    localparam logic signed [YW-1:0] SPRITE_H_S = YW'(SPRITE_HEIGHT);
    localparam logic signed [YW-1:0] SCREEN_H_S = YW'(SCREEN_HEIGHT);
    localparam logic [STROBE_WIDTH-1:0] TICK_LAST = STROBE_WIDTH'(STROBE_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE, PLACE, AIM, MOVE, UPDATE, CHECK, BOUNCE
    } state_t;

    state_t                   state_reg, state_next;
    logic [DX_WIDTH-1:0]      dx_reg;
    logic [DY_WIDTH-1:0]      dy_reg;
    logic [7:0]               bounce_count_reg;
    logic [STROBE_WIDTH-1:0]  tick_cnt_reg;
    logic                     tick;

    // Edge detection: look one step ahead with sign-extended, non-truncating arithmetic.
    logic signed [XW-1:0] x_ext, dx_ext, x_lo_sum, x_hi_sum;
    logic signed [YW-1:0] y_ext, dy_ext, y_lo_sum, y_hi_sum;
    logic                 dx_neg, dx_pos, dy_neg, dy_pos, hit_x, hit_y;

    assign x_ext    = {2'b00, spr.sprite_x};
    assign y_ext    = {2'b00, spr.sprite_y};
    assign dx_ext   = {{(XW-DX_WIDTH){dx_reg[DX_WIDTH-1]}}, dx_reg};
    assign dy_ext   = {{(YW-DY_WIDTH){dy_reg[DY_WIDTH-1]}}, dy_reg};
    assign x_lo_sum = x_ext + dx_ext;
    assign y_lo_sum = y_ext + dy_ext;
    assign x_hi_sum = x_ext + SPRITE_W_S + dx_ext;
    assign y_hi_sum = y_ext + SPRITE_H_S + dy_ext;
    assign dx_neg   = dx_reg[DX_WIDTH-1];
    assign dy_neg   = dy_reg[DY_WIDTH-1];
    assign dx_pos   = !dx_neg && (dx_reg != '0);
    assign dy_pos   = !dy_neg && (dy_reg != '0);
    assign hit_x    = (dx_neg && x_lo_sum[XW-1]) || (dx_pos && (x_hi_sum > SCREEN_W_S));
    assign hit_y    = (dy_neg && y_lo_sum[YW-1]) || (dy_pos && (y_hi_sum > SCREEN_H_S));

    assign tick = (tick_cnt_reg == TICK_LAST);

    // Free-running frame-tick counter; ticks seen outside MOVE are simply lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and Moore-decoded strobes; halt overrides every transition.
    always_comb begin
        state_next               = state_reg;
        spr.sprite_write_xy      = 1'b0;
        spr.sprite_write_dxy     = 1'b0;
        spr.sprite_enable_update = 1'b0;
        busy                     = (state_reg != IDLE);
        case (state_reg)
            IDLE:   if (launch) state_next = PLACE;
            PLACE:  begin
                spr.sprite_write_xy = 1'b1;
                state_next          = AIM;
            end
            AIM:    begin
                spr.sprite_write_dxy = 1'b1;
                state_next           = MOVE;
            end
            MOVE:   if (tick) state_next = UPDATE;
            UPDATE: begin
                spr.sprite_enable_update = 1'b1;
                state_next               = CHECK;
            end
            CHECK:  begin
`ifdef GAME_SPRITE_BOTTOM_MISS_EN
                if (dy_pos && hit_y) begin
                    state_next = PLACE;
                end else if (hit_x || hit_y) begin
                    state_next = BOUNCE;
                end else begin
                    state_next = MOVE;
                end
`else
                if (hit_x || hit_y) begin
                    state_next = BOUNCE;
                end else begin
                    state_next = MOVE;
                end
`endif
            end
            BOUNCE: begin
                spr.sprite_write_dxy = 1'b1;
                state_next           = MOVE;
            end
            default: state_next = IDLE;
        endcase
        if (halt && (state_reg != IDLE)) begin
            state_next = IDLE;
        end
    end

    // Speed and bounce counter update on entry to PLACE (restart) or BOUNCE (reflect).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dx_reg           <= DX_WIDTH'(START_DX);
            dy_reg           <= DY_WIDTH'(START_DY);
            bounce_count_reg <= '0;
        end else if (state_next == PLACE) begin
            dx_reg           <= DX_WIDTH'(START_DX);
            dy_reg           <= DY_WIDTH'(START_DY);
            bounce_count_reg <= '0;
        end else if (state_next == BOUNCE) begin
            if (hit_x) dx_reg <= -dx_reg;
            if (hit_y) dy_reg <= -dy_reg;
            if (bounce_count_reg != 8'hFF) begin
                bounce_count_reg <= bounce_count_reg + 8'd1;
            end
        end
    end

    assign spr.sprite_write_x  = X_WIDTH'(START_X);
    assign spr.sprite_write_y  = Y_WIDTH'(START_Y);
    assign spr.sprite_write_dx = dx_reg;
    assign spr.sprite_write_dy = dy_reg;
    assign bounce_count        = bounce_count_reg;

endmodule

// File: tb/tb_game_sprite_bounce_ctrl.sv
// Directed bench for game_sprite_bounce_ctrl. Two instances share the clock and reset:
// A uses the default start (0,0) speed (+1,+1); B starts at (1,1) with speed (-1,-1)
// so its first step lands in the top-left corner. Each has a small behavioural sprite
// block (x+=dx, y+=dy on enable_update). Model A can be repositioned by the bench, and
// can be pinned so that every look-ahead hits a vertical edge.
module tb_game_sprite_bounce_ctrl;

    logic       clk;
    logic       reset;
    logic       launch_a, halt_a, launch_b, halt_b;
    logic       busy_a, busy_b;
    logic [7:0] bounce_count_a, bounce_count_b;

    int tests_run = 0;
    int tests_failed = 0;

    game_sprite_bounce_ctrl_if #(.X_WIDTH(10), .Y_WIDTH(10), .DX_WIDTH(2), .DY_WIDTH(2)) ifa ();
    game_sprite_bounce_ctrl_if #(.X_WIDTH(10), .Y_WIDTH(10), .DX_WIDTH(2), .DY_WIDTH(2)) ifb ();

    game_sprite_bounce_ctrl #(
        .STROBE_WIDTH(3), .STROBE_PERIOD(4)
    ) dut_a (
        .clk(clk), .reset(reset), .launch(launch_a), .halt(halt_a),
        .spr(ifa), .busy(busy_a), .bounce_count(bounce_count_a)
    );

    game_sprite_bounce_ctrl #(
        .START_X(1), .START_Y(1), .START_DX(-1), .START_DY(-1),
        .STROBE_WIDTH(3), .STROBE_PERIOD(4)
    ) dut_b (
        .clk(clk), .reset(reset), .launch(launch_b), .halt(halt_b),
        .spr(ifb), .busy(busy_b), .bounce_count(bounce_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite block model A (with reposition and pin controls)
    logic [9:0] ma_x, ma_y, ma_ovr_x, ma_ovr_y;
    logic [1:0] ma_dx, ma_dy;
    logic       ma_ovr, ma_pin;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma_x <= '0; ma_y <= '0; ma_dx <= '0; ma_dy <= '0;
        end else begin
            if (ifa.sprite_write_dxy) begin
                ma_dx <= ifa.sprite_write_dx;
                ma_dy <= ifa.sprite_write_dy;
            end
            if (ma_ovr) begin
                ma_x <= ma_ovr_x;
                ma_y <= ma_ovr_y;
            end else if (ifa.sprite_write_xy) begin
                ma_x <= ifa.sprite_write_x;
                ma_y <= ifa.sprite_write_y;
            end else if (ifa.sprite_enable_update) begin
                ma_x <= ma_x + {{8{ma_dx[1]}}, ma_dx};
                ma_y <= ma_y + {{8{ma_dy[1]}}, ma_dy};
            end
        end
    end
    assign ifa.sprite_x = ma_pin ? (ma_dx[1] ? 10'd0 : 10'd632) : ma_x;
    assign ifa.sprite_y = ma_pin ? 10'd200 : ma_y;

    // Sprite block model B
    logic [9:0] mb_x, mb_y;
    logic [1:0] mb_dx, mb_dy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mb_x <= '0; mb_y <= '0; mb_dx <= '0; mb_dy <= '0;
        end else begin
            if (ifb.sprite_write_dxy) begin
                mb_dx <= ifb.sprite_write_dx;
                mb_dy <= ifb.sprite_write_dy;
            end
            if (ifb.sprite_write_xy) begin
                mb_x <= ifb.sprite_write_x;
                mb_y <= ifb.sprite_write_y;
            end else if (ifb.sprite_enable_update) begin
                mb_x <= mb_x + {{8{mb_dx[1]}}, mb_dx};
                mb_y <= mb_y + {{8{mb_dy[1]}}, mb_dy};
            end
        end
    end
    assign ifb.sprite_x = mb_x;
    assign ifb.sprite_y = mb_y;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    // Launch A; checks PLACE and AIM cycles, optionally repositions the sprite model.
    // Returns just after the edge that enters MOVE.
    task automatic launch_dut_a(input bit ovr, input logic [9:0] ox, input logic [9:0] oy);
        launch_a = 1'b1;
        @(negedge clk);
        launch_a = 1'b0;
        check("a_place_write_xy", 32'(ifa.sprite_write_xy), 1);
        check("a_place_dxy_low", 32'(ifa.sprite_write_dxy), 0);
        check("a_place_x", 32'(ifa.sprite_write_x), 0);
        check("a_place_y", 32'(ifa.sprite_write_y), 0);
        check("a_place_busy", 32'(busy_a), 1);
        check("a_place_bounce_count", 32'(bounce_count_a), 0);
        @(negedge clk);
        check("a_aim_write_dxy", 32'(ifa.sprite_write_dxy), 1);
        check("a_aim_dx", 32'(ifa.sprite_write_dx), 1);
        check("a_aim_dy", 32'(ifa.sprite_write_dy), 1);
        if (ovr) begin
            ma_ovr   = 1'b1;
            ma_ovr_x = ox;
            ma_ovr_y = oy;
        end
        @(posedge clk);
        #1 ma_ovr = 1'b0;
    endtask

    // Wait (bounded) for the UPDATE strobe of A; n = negedges waited.
    task automatic wait_update_a(input string tag, output int n);
        bit found = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            n++;
            if (ifa.sprite_enable_update) found = 1'b1;
        end
        check(tag, 32'(found), 1);
    endtask

    task automatic halt_dut_a();
        halt_a = 1'b1;
        @(negedge clk);
        halt_a = 1'b0;
        check("a_halt_busy", 32'(busy_a), 0);
    endtask

    initial begin
        int  n, nupd, nb;
        bit  found, strobe_seen, xy_seen;

        reset = 1'b0;
        launch_a = 1'b0; halt_a = 1'b0; launch_b = 1'b0; halt_b = 1'b0;
        ma_ovr = 1'b0; ma_ovr_x = '0; ma_ovr_y = '0; ma_pin = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_write_xy", 32'(ifa.sprite_write_xy), 0);
        check("rst_write_dxy", 32'(ifa.sprite_write_dxy), 0);
        check("rst_enable_update", 32'(ifa.sprite_enable_update), 0);
        check("rst_bounce_count", 32'(bounce_count_a), 0);
        check("rst_dx", 32'(ifa.sprite_write_dx), 1);
        check("rst_dy", 32'(ifa.sprite_write_dy), 1);
        check("rst_b_dx", 32'(ifb.sprite_write_dx), 3);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_stays_idle", 32'(busy_a), 0);

        // Launch, first step latency, then halt during UPDATE
        launch_dut_a(1'b0, 10'd0, 10'd0);
        wait_update_a("t1_update_seen", n);
        check("t1_update_latency_ok", 32'(n <= 5), 1);
        halt_a = 1'b1;
        @(negedge clk);
        halt_a = 1'b0;
        check("t4_halt_busy", 32'(busy_a), 0);
        strobe_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ifa.sprite_write_xy || ifa.sprite_write_dxy || ifa.sprite_enable_update) strobe_seen = 1'b1;
            @(negedge clk);
        end
        check("t4_no_strobes_after_halt", 32'(strobe_seen), 0);
        check("t4_dx_held", 32'(ifa.sprite_write_dx), 1);
        check("t4_busy_stays_low", 32'(busy_a), 0);

        // Right-edge bounce from x=628
        launch_dut_a(1'b1, 10'd628, 10'd100);
        nupd = 0; found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (ifa.sprite_enable_update) nupd++;
            if (ifa.sprite_write_dxy) found = 1'b1;
        end
        check("t2_bounce_seen", 32'(found), 1);
        check("t2_steps_before_bounce", 32'(nupd), 4);
        check("t2_bounce_dx", 32'(ifa.sprite_write_dx), 3);
        check("t2_bounce_dy", 32'(ifa.sprite_write_dy), 1);
        check("t2_bounce_count", 32'(bounce_count_a), 1);
        wait_update_a("t2_update_after_bounce", n);
        @(negedge clk);
        check("t2_x_decreasing", 32'(ma_x), 631);
        halt_dut_a();
        check("t4_dx_held_after_halt", 32'(ifa.sprite_write_dx), 3);
        check("t4_count_held_after_halt", 32'(bounce_count_a), 1);

        // Relaunch (count and speed restart), right-edge bounce, then bottom edge
        launch_dut_a(1'b1, 10'd631, 10'd470);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ifa.sprite_write_dxy) found = 1'b1;
        end
        check("t6_first_bounce_seen", 32'(found), 1);
        check("t6_first_bounce_count", 32'(bounce_count_a), 1);
        found = 1'b0; xy_seen = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ifa.sprite_write_xy || ifa.sprite_write_dxy) begin
                found = 1'b1;
                xy_seen = ifa.sprite_write_xy;
            end
        end
        check("t6_bottom_strobe_seen", 32'(found), 1);
`ifdef GAME_SPRITE_BOTTOM_MISS_EN
        check("t6_miss_write_xy", 32'(xy_seen), 1);
        check("t6_miss_x", 32'(ifa.sprite_write_x), 0);
        check("t6_miss_y", 32'(ifa.sprite_write_y), 0);
        check("t6_miss_count", 32'(bounce_count_a), 0);
        @(negedge clk);
        check("t6_miss_aim_dx", 32'(ifa.sprite_write_dx), 1);
        check("t6_miss_aim_dy", 32'(ifa.sprite_write_dy), 1);
`else
        check("t6_bottom_write_xy", 32'(xy_seen), 0);
        check("t6_bottom_dy", 32'(ifa.sprite_write_dy), 3);
        check("t6_bottom_dx", 32'(ifa.sprite_write_dx), 3);
        check("t6_bottom_count", 32'(bounce_count_a), 2);
`endif
        halt_dut_a();

        // Saturation: every look-ahead hits a vertical edge
        launch_dut_a(1'b0, 10'd0, 10'd0);
        ma_pin = 1'b1;
        nb = 0;
        for (int i = 0; i < 4000 && nb < 300; i++) begin
            @(negedge clk);
            if (ifa.sprite_write_dxy) begin
                nb++;
                if (nb == 10) check("t5_count_at_10", 32'(bounce_count_a), 10);
            end
        end
        check("t5_reached_300", 32'(nb), 300);
        check("t5_saturated", 32'(bounce_count_a), 255);
        halt_dut_a();
        ma_pin = 1'b0;

        // Corner bounce on B, launched with halt also high in IDLE
        launch_b = 1'b1; halt_b = 1'b1;
        @(negedge clk);
        launch_b = 1'b0; halt_b = 1'b0;
        check("t3_place_write_xy", 32'(ifb.sprite_write_xy), 1);
        check("t3_place_x", 32'(ifb.sprite_write_x), 1);
        @(negedge clk);
        check("t3_aim_dx", 32'(ifb.sprite_write_dx), 3);
        check("t3_aim_dy", 32'(ifb.sprite_write_dy), 3);
        nupd = 0; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ifb.sprite_enable_update) nupd++;
            if (ifb.sprite_write_dxy) found = 1'b1;
        end
        check("t3_bounce_seen", 32'(found), 1);
        check("t3_steps_before_bounce", 32'(nupd), 1);
        check("t3_corner_dx", 32'(ifb.sprite_write_dx), 1);
        check("t3_corner_dy", 32'(ifb.sprite_write_dy), 1);
        check("t3_corner_count", 32'(bounce_count_b), 1);
        repeat (20) @(negedge clk);
        check("t3_count_unchanged", 32'(bounce_count_b), 1);
        check("t3_still_busy", 32'(busy_b), 1);

        // Asynchronous reset mid-motion takes effect without a clock edge
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy_b), 0);
        check("arst_strobes", 32'({ifb.sprite_write_xy, ifb.sprite_write_dxy, ifb.sprite_enable_update}), 0);
        check("arst_dx", 32'(ifb.sprite_write_dx), 3);
        check("arst_count", 32'(bounce_count_b), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
